fwd_ctrl: RTL and testbench

FWD_CTRL -- requirements
Module: fwd_ctrl

---
 rtl/fwd_ctrl.sv | 130 +++++++++++++
 tb/tb_fwd_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard control for a 5-stage pipeline.
// Tracks EX/MEM/WB destinations and registers EX operand-mux selects one cycle ahead.
module fwd_ctrl #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              flush,
   input  logic              cnt_clr,
   output logic              fwd_a_c0,
   output logic              fwd_a_c1,
   output logic              fwd_b_c0,
   output logic              fwd_b_c1,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic [REG_AW-1:0] r_ex_rd, r_mem_rd, r_wb_rd;
   logic              r_ex_wr, r_mem_wr, r_wb_wr;
   logic              r_ex_ld, r_mem_ld, r_wb_ld;
   logic [1:0]        r_fwd_a, r_fwd_b;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic              w_stall;
   logic              w_rs_hit, w_rt_hit;
   logic              w_issue;
   logic [1:0]        w_sel_a, w_sel_b;

   // Nearest producer wins: EX (01), then MEM (10), then WB (11), else register file.
   function automatic logic [1:0] f_sel(
      input logic [REG_AW-1:0] src,
      input logic              used,
      input logic              blocked,
      input logic [REG_AW-1:0] ex_rd,
      input logic              ex_wr,
      input logic [REG_AW-1:0] mem_rd,
      input logic              mem_wr,
      input logic [REG_AW-1:0] wb_rd,
      input logic              wb_wr
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (!blocked && used && (src != '0)) begin
         if (ex_wr && (ex_rd == src)) begin
            sel = 2'b01;
         end else if (mem_wr && (mem_rd == src)) begin
            sel = 2'b10;
         end else if (wb_wr && (wb_rd == src)) begin
            sel = 2'b11;
         end
      end
      return sel;
   endfunction

   always_comb begin
      w_rs_hit = id_rs_used && (id_rs != '0) && (id_rs == r_ex_rd);
      w_rt_hit = id_rt_used && (id_rt != '0) && (id_rt == r_ex_rd);
      // Gated by rst_n so stall stays low while held in reset.
      w_stall  = rst_n && id_valid && !flush && r_ex_ld && r_ex_wr && (w_rs_hit || w_rt_hit);
      w_issue  = id_valid && !flush && !w_stall;
      w_sel_a  = f_sel(id_rs, id_rs_used, !w_issue, r_ex_rd, r_ex_wr,
                       r_mem_rd, r_mem_wr, r_wb_rd, r_wb_wr);
      w_sel_b  = f_sel(id_rt, id_rt_used, !w_issue, r_ex_rd, r_ex_wr,
                       r_mem_rd, r_mem_wr, r_wb_rd, r_wb_wr);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ex_rd  <= '0;
         r_ex_wr  <= 1'b0;
         r_ex_ld  <= 1'b0;
         r_mem_rd <= '0;
         r_mem_wr <= 1'b0;
         r_mem_ld <= 1'b0;
         r_wb_rd  <= '0;
         r_wb_wr  <= 1'b0;
         r_wb_ld  <= 1'b0;
         r_fwd_a  <= 2'b00;
         r_fwd_b  <= 2'b00;
      end else begin
         r_wb_rd  <= r_mem_rd;
         r_wb_wr  <= r_mem_wr;
         r_wb_ld  <= r_mem_ld;
         r_mem_rd <= r_ex_rd;
         r_mem_wr <= r_ex_wr;
         r_mem_ld <= r_ex_ld;
         if (w_issue) begin
            r_ex_rd <= id_rd;
            r_ex_wr <= id_reg_write && (id_rd != '0);
            r_ex_ld <= id_mem_read;
         end else begin
            r_ex_rd <= '0;
            r_ex_wr <= 1'b0;
            r_ex_ld <= 1'b0;
         end
         r_fwd_a <= w_sel_a;
         r_fwd_b <= w_sel_b;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (cnt_clr) begin
         r_stall_cnt <= '0;
      end else if (w_stall && !(&r_stall_cnt)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign stall     = w_stall;
   assign stall_cnt = r_stall_cnt;
   assign fwd_a_c0  = r_fwd_a[0];
   assign fwd_a_c1  = r_fwd_a[1];
   assign fwd_b_c0  = r_fwd_b[0];
   assign fwd_b_c1  = r_fwd_b[1];

   logic w_unused;
   assign w_unused = r_wb_ld;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Scoreboard bench for fwd_ctrl: directed hazard scenarios plus random instruction streams,
// checked against a producer-history reference model.
module tb_fwd_ctrl;

   localparam int REG_AW = 5;
   // Narrow counter so saturation is reachable in a short run.
   localparam int CNT_W  = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              id_valid;
   logic [REG_AW-1:0] id_rs, id_rt, id_rd;
   logic              id_rs_used, id_rt_used, id_reg_write, id_mem_read;
   logic              flush, cnt_clr;
   logic              fwd_a_c0, fwd_a_c1, fwd_b_c0, fwd_b_c1;
   logic              stall;
   logic [CNT_W-1:0]  stall_cnt;

   fwd_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_rs_used  (id_rs_used),
      .id_rt_used  (id_rt_used),
      .id_rd       (id_rd),
      .id_reg_write(id_reg_write),
      .id_mem_read (id_mem_read),
      .flush       (flush),
      .cnt_clr     (cnt_clr),
      .fwd_a_c0    (fwd_a_c0),
      .fwd_a_c1    (fwd_a_c1),
      .fwd_b_c0    (fwd_b_c0),
      .fwd_b_c1    (fwd_b_c1),
      .stall       (stall),
      .stall_cnt   (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int rd;
      bit wr;
      bit ld;
   } prod_t;

   typedef struct {
      int a;
      int b;
      int cnt;
   } exp_reg_t;

   prod_t    hist[3];  // instructions that entered EX: [0]=EX, [1]=MEM, [2]=WB
   int       m_cnt;
   bit       q_stall[$];
   exp_reg_t q_reg[$];
   int       errors = 0;
   int       checks = 0;

   function automatic int ref_sel(input int src, input bit used, input bit blocked);
      if (blocked || !used || src == 0) return 0;
      for (int d = 0; d < 3; d++) begin
         if (hist[d].wr && hist[d].rd == src) return d + 1;
      end
      return 0;
   endfunction

   task automatic issue(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                        input int rd, input bit w, input bit ld, input bit fl, input bit clr,
                        input bit rn);
      bit       exp_stall;
      bit       enter;
      exp_reg_t e;
      prod_t    p;
      @(negedge clk);
      rst_n = rn; id_valid = v; flush = fl; cnt_clr = clr;
      id_rs = rs[REG_AW-1:0]; id_rs_used = rsu;
      id_rt = rt[REG_AW-1:0]; id_rt_used = rtu;
      id_rd = rd[REG_AW-1:0]; id_reg_write = w; id_mem_read = ld;
      #1;
      // A load in EX whose result a used nonzero source needs cannot be forwarded yet.
      exp_stall = rn && v && !fl && hist[0].ld && hist[0].wr &&
                  ((rsu && rs != 0 && hist[0].rd == rs) || (rtu && rt != 0 && hist[0].rd == rt));
      q_stall.push_back(exp_stall);
      enter = v && !fl && !exp_stall;
      if (!rn) begin
         for (int i = 0; i < 3; i++) hist[i] = '{rd: 0, wr: 0, ld: 0};
         m_cnt = 0;
         e = '{a: 0, b: 0, cnt: 0};
      end else begin
         e.a = ref_sel(rs, rsu, !enter);
         e.b = ref_sel(rt, rtu, !enter);
         if (clr) m_cnt = 0;
         else if (exp_stall && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
         e.cnt = m_cnt;
         p = enter ? '{rd: rd, wr: (w && rd != 0), ld: ld} : '{rd: 0, wr: 0, ld: 0};
         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = p;
      end
      q_reg.push_back(e);
   endtask

   task automatic idle();
      issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   // Combinational stall, sampled mid-cycle after the driver has settled inputs.
   initial begin
      bit exp_s;
      forever begin
         @(negedge clk);
         #2;
         if (q_stall.size() > 0) begin
            exp_s = q_stall.pop_front();
            checks++;
            if (stall !== exp_s) begin
               errors++;
               $display("FAIL stall @%0t: got %b expected %b", $time, stall, exp_s);
            end
         end
      end
   end

   // Registered selects and counter, sampled just after the edge.
   initial begin
      exp_reg_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q_reg.size() > 0) begin
            e = q_reg.pop_front();
            checks++;
            if ({fwd_a_c1, fwd_a_c0} !== e.a[1:0] || {fwd_b_c1, fwd_b_c0} !== e.b[1:0]) begin
               errors++;
               $display("FAIL fwd_sel @%0t: got A=%b%b B=%b%b expected A=%0d B=%0d", $time,
                        fwd_a_c1, fwd_a_c0, fwd_b_c1, fwd_b_c0, e.a, e.b);
            end
            checks++;
            if (stall_cnt !== e.cnt[CNT_W-1:0]) begin
               errors++;
               $display("FAIL stall_cnt @%0t: got %0d expected %0d", $time, stall_cnt, e.cnt);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 3; i++) hist[i] = '{rd: 0, wr: 0, ld: 0};
      m_cnt = 0;
      // Reset with a would-be hazard on the ID inputs.
      issue(1, 2, 1, 2, 1, 6, 1, 1, 0, 0, 0);
      issue(1, 2, 1, 2, 1, 6, 1, 0, 0, 0, 0);
      idle();
      // Back-to-back ALU: add r3,r1,r2 ; sub r5,r3,r4
      issue(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 1);
      issue(1, 3, 1, 4, 1, 5, 1, 0, 0, 0, 1);
      idle(); idle(); idle();
      // Load-use: lw r2,(r1) ; add r6,r2,r2 held until it issues
      issue(1, 1, 1, 0, 0, 2, 1, 1, 0, 0, 1);
      issue(1, 2, 1, 2, 1, 6, 1, 0, 0, 0, 1);
      issue(1, 2, 1, 2, 1, 6, 1, 0, 0, 0, 1);
      idle(); idle(); idle();
      // Distance 3: write r7, two independent ops, then read r7 on rt
      issue(1, 1, 1, 0, 0, 7, 1, 0, 0, 0, 1);
      issue(1, 1, 1, 0, 0, 8, 1, 0, 0, 0, 1);
      issue(1, 1, 1, 0, 0, 9, 1, 0, 0, 0, 1);
      issue(1, 1, 1, 7, 1, 10, 1, 0, 0, 0, 1);
      idle(); idle(); idle();
      // r0 is never a producer
      issue(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1);
      issue(1, 0, 1, 0, 1, 4, 1, 0, 0, 0, 1);
      idle(); idle(); idle();
      // Flush beats a load-use hazard
      issue(1, 1, 1, 0, 0, 2, 1, 1, 0, 0, 1);
      issue(1, 2, 1, 2, 1, 6, 1, 0, 1, 0, 1);
      idle(); idle(); idle();
      // Reset mid-stall, then re-present the consumer
      issue(1, 1, 1, 0, 0, 2, 1, 1, 0, 0, 1);
      issue(1, 2, 1, 2, 1, 6, 1, 0, 0, 0, 0);
      issue(1, 2, 1, 2, 1, 6, 1, 0, 0, 0, 1);
      idle(); idle(); idle();
      // Saturate the counter: lw r2,(r2) repeated stalls every other cycle
      for (int i = 0; i < 2 * CNT_MAX + 20; i++) issue(1, 2, 1, 0, 0, 2, 1, 1, 0, 0, 1);
      idle();
      // cnt_clr together with a stall
      issue(1, 1, 1, 0, 0, 2, 1, 1, 0, 0, 1);
      issue(1, 2, 1, 2, 1, 6, 1, 0, 0, 1, 1);
      issue(1, 2, 1, 2, 1, 6, 1, 0, 0, 0, 1);
      idle(); idle();
      // Random streams over a small register set to provoke dense hazards
      for (int i = 0; i < 600; i++) begin
         issue($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
               $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 99) != 0);
      end
      @(posedge clk);
      #3;
      checks++;
      if (q_reg.size() != 0 || q_stall.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d pending expected 0/0", q_reg.size(), q_stall.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
